// File: rtl/fb_arbiter_if.sv
// Bundle of the scanout, host-write, fill-control and RAM-port signals around fb_arbiter.
// The arbiter uses the slave modport; the surrounding logic uses master.
interface fb_arbiter_if #(
    parameter int AW = 13
);
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic          rd_valid;
    logic [7:0]    rd_data;
    logic          wr_valid;
    logic          wr_ready;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic          fill_start;
    logic [7:0]    fill_color;
    logic          fill_busy;
    logic          fill_done;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic [7:0]    mem_rdata;

    modport slave (
        input  rd_req, rd_addr, wr_valid, wr_addr, wr_data, fill_start, fill_color, mem_rdata,
        output rd_valid, rd_data, wr_ready, fill_busy, fill_done,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output rd_req, rd_addr, wr_valid, wr_addr, wr_data, fill_start, fill_color, mem_rdata,
        input  rd_valid, rd_data, wr_ready, fill_busy, fill_done,
               mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/fb_arbiter.sv
// Framebuffer RAM port arbiter: scanout reads always win, then the clear-screen fill,
// then host writes drained from a small FIFO.
//
// state   | meaning
// IDLE    | serve reads and drain host FIFO
// FILL    | write fill colour to cells 0..CELLS-1 in idle read slots
module fb_arbiter #(
    parameter int CELLS      = 4800,
    parameter int AW         = 13,
    parameter int FIFO_DEPTH = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    fb_arbiter_if.slave bus
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW-1:0] LAST_CELL = AW'(CELLS - 1);
    localparam logic [AW-1:0] NUM_CELLS = AW'(CELLS);
    localparam logic [PW:0]   FULL_CNT  = (PW+1)'(FIFO_DEPTH);

    typedef enum logic {ST_IDLE, ST_FILL} state_t;

    state_t        r_state;
    state_t        w_next_state;

    logic [AW-1:0] r_fifo_addr [FIFO_DEPTH];
    logic [7:0]    r_fifo_data [FIFO_DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [PW:0]   r_count;

    logic [AW-1:0] r_fill_cnt;
    logic [7:0]    r_fill_color;
    logic          r_rd_valid;
    logic          r_fill_done;

    logic          w_empty;
    logic          w_full;
    logic          w_push;
    logic          w_pop;
    logic          w_fill_wr;
    logic          w_fill_go;
    logic          w_fill_last;

    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == FULL_CNT);
    assign w_push      = bus.wr_valid && bus.wr_ready;
    assign w_fill_go   = (r_state == ST_IDLE) && bus.fill_start && w_empty;
    assign w_fill_last = w_fill_wr && (r_fill_cnt == LAST_CELL);

    assign bus.fill_busy = (r_state == ST_FILL);
    assign bus.wr_ready  = !w_full && !bus.fill_busy && !i_rst;
    assign bus.rd_valid  = r_rd_valid;
    assign bus.rd_data   = bus.mem_rdata;
    assign bus.fill_done = r_fill_done;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (w_fill_go)   w_next_state = ST_FILL;
            ST_FILL: if (w_fill_last) w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        w_fill_wr     = 1'b0;
        w_pop         = 1'b0;
        if (bus.rd_req) begin
            bus.mem_en   = 1'b1;
            bus.mem_addr = bus.rd_addr;
        end else if (r_state == ST_FILL) begin
            bus.mem_en    = 1'b1;
            bus.mem_we    = 1'b1;
            bus.mem_addr  = r_fill_cnt;
            bus.mem_wdata = r_fill_color;
            w_fill_wr     = 1'b1;
        end else if (!w_empty) begin
            w_pop = 1'b1;
            // Out-of-range host addresses consume their slot without touching RAM.
            if (r_fifo_addr[r_rptr] < NUM_CELLS) begin
                bus.mem_en    = 1'b1;
                bus.mem_we    = 1'b1;
                bus.mem_addr  = r_fifo_addr[r_rptr];
                bus.mem_wdata = r_fifo_data[r_rptr];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_count      <= '0;
            r_fill_cnt   <= '0;
            r_fill_color <= '0;
            r_rd_valid   <= 1'b0;
            r_fill_done  <= 1'b0;
        end else begin
            r_rd_valid  <= bus.rd_req;
            r_fill_done <= w_fill_last;
            if (w_push) r_wptr <= r_wptr + PW'(1);
            if (w_pop)  r_rptr <= r_rptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PW+1)'(1);
                2'b01:   r_count <= r_count - (PW+1)'(1);
                default: r_count <= r_count;
            endcase
            if (w_fill_go) begin
                r_fill_cnt   <= '0;
                r_fill_color <= bus.fill_color;
            end else if (w_fill_wr) begin
                r_fill_cnt <= r_fill_cnt + AW'(1);
            end
        end
    end

    // Storage needs no reset: pushes are blocked while reset is asserted.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_fifo_addr[r_wptr] <= bus.wr_addr;
            r_fifo_data[r_wptr] <= bus.wr_data;
        end
    end
endmodule

// File: tb/tb_fb_arbiter.sv
// Directed bench for fb_arbiter with a behavioural single-port RAM behind the mem_* port.
module tb_fb_arbiter;
    logic clk;
    logic rst;
    int   n_pass;
    int   n_total;
    logic [7:0] ram [0:8191];

    fb_arbiter_if #(.AW(13)) bus ();

    fb_arbiter #(.CELLS(4800), .AW(13), .FIFO_DEPTH(4)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
            else            bus.mem_rdata     <= ram[bus.mem_addr];
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic next_cyc();
        @(negedge clk);
    endtask

    initial begin
        int c;
        int k;
        n_pass  = 0;
        n_total = 0;
        for (int i = 0; i < 8192; i++) ram[i] = 8'h00;
        bus.mem_rdata  = 8'h00;
        rst            = 1'b1;
        bus.rd_req     = 1'b0;
        bus.rd_addr    = '0;
        bus.wr_valid   = 1'b1;
        bus.wr_addr    = 13'd5;
        bus.wr_data    = 8'h55;
        bus.fill_start = 1'b1;
        bus.fill_color = 8'hFF;

        // Reset held across two edges with requests active
        @(negedge clk); #1;
        chk("rst1", {bus.wr_ready, bus.fill_busy, bus.mem_we, bus.rd_valid}, 4'b0000);
        @(posedge clk); #1;
        chk("rst2", {bus.wr_ready, bus.fill_busy, bus.mem_we, bus.rd_valid}, 4'b0000);
        next_cyc();
        rst = 1'b0; bus.wr_valid = 1'b0; bus.fill_start = 1'b0;
        #1;
        chk("post_rst_ready", bus.wr_ready, 1);
        chk("post_rst_idle", {bus.mem_en, bus.fill_busy}, 2'b00);
        next_cyc();
        chk("post_rst_noen", bus.mem_en, 0);

        // Write then read
        bus.wr_valid = 1'b1; bus.wr_addr = 13'd100; bus.wr_data = 8'hE0;
        #1 chk("wr_ready_idle", bus.wr_ready, 1);
        next_cyc();
        bus.wr_valid = 1'b0;
        #1 chk("wr_100", {bus.mem_en, bus.mem_we, bus.mem_wdata, bus.mem_addr}, {2'b11, 8'hE0, 13'd100});
        next_cyc();
        bus.rd_req = 1'b1; bus.rd_addr = 13'd100;
        #1 chk("rd_100_port", {bus.mem_en, bus.mem_we, bus.mem_addr}, {2'b10, 13'd100});
        next_cyc();
        bus.rd_req = 1'b0;
        #1 chk("rd_100_data", {bus.rd_valid, bus.rd_data}, {1'b1, 8'hE0});
        next_cyc();
        chk("rd_valid_drop", bus.rd_valid, 0);

        // Contention: reads block four queued writes
        bus.rd_req = 1'b1; bus.rd_addr = 13'd0;
        for (int i = 1; i <= 4; i++) begin
            bus.wr_valid = 1'b1; bus.wr_addr = 13'(i); bus.wr_data = 8'(i * 17);
            #1 chk("cont_push_ready", {bus.wr_ready, bus.mem_we}, 2'b10);
            next_cyc();
        end
        bus.wr_valid = 1'b0;
        #1 chk("cont_full", {bus.wr_ready, bus.mem_we}, 2'b00);
        next_cyc();
        bus.rd_req = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            #1 chk("cont_drain", {bus.wr_ready, bus.mem_en, bus.mem_we, bus.mem_wdata, bus.mem_addr},
                   {(i == 1) ? 1'b0 : 1'b1, 2'b11, 8'(i * 17), 13'(i)});
            next_cyc();
        end
        chk("cont_empty", bus.mem_en, 0);

        // Dropped out-of-range write and ignored fill_start
        bus.wr_valid = 1'b1; bus.wr_addr = 13'd4800; bus.wr_data = 8'h77;
        next_cyc();
        bus.wr_valid = 1'b0; bus.fill_start = 1'b1; bus.fill_color = 8'h1C;
        #1 chk("drop_no_en", bus.mem_en, 0);
        next_cyc();
        bus.fill_start = 1'b0;
        #1 chk("start_ignored", {bus.fill_busy, bus.mem_en}, 2'b00);
        next_cyc();

        // Fill without reads
        bus.fill_start = 1'b1; bus.fill_color = 8'h1C;
        #1 chk("fill_n", {bus.fill_busy, bus.wr_ready}, 2'b01);
        next_cyc();
        bus.fill_start = 1'b0;
        for (k = 0; k < 4800; k++) begin
            #1 chk("fill_cyc",
                   {bus.fill_busy, bus.wr_ready, bus.mem_en, bus.mem_we, bus.fill_done, bus.mem_wdata, bus.mem_addr},
                   {5'b10110, 8'h1C, 13'(k)});
            next_cyc();
        end
        #1 chk("fill_done", {bus.fill_busy, bus.fill_done, bus.mem_en, bus.wr_ready}, 4'b0101);
        next_cyc();
        chk("fill_done_pulse", bus.fill_done, 0);
        chk("ram_4799_1c", ram[4799], 8'h1C);

        // Fill with a read on every other cycle
        bus.fill_start = 1'b1; bus.fill_color = 8'hE3;
        next_cyc();
        bus.fill_start = 1'b0; bus.rd_addr = 13'd7;
        k = 0;
        c = 0;
        while (k < 4800 && c < 20000) begin
            bus.rd_req = c[0];
            #1;
            if (bus.rd_req)
                chk("fillrd_read", {bus.fill_busy, bus.mem_en, bus.mem_we, bus.mem_addr}, {3'b110, 13'd7});
            else begin
                chk("fillrd_write", {bus.fill_busy, bus.mem_we, bus.mem_wdata, bus.mem_addr},
                    {2'b11, 8'hE3, 13'(k)});
                k++;
            end
            c++;
            next_cyc();
        end
        bus.rd_req = 1'b0;
        chk("fillrd_addrs", k, 4800);
        chk("fillrd_len", c, 9599);
        #1 chk("fillrd_done", {bus.fill_busy, bus.fill_done}, 2'b01);
        next_cyc();

        // Reset in the middle of a fill
        bus.fill_start = 1'b1; bus.fill_color = 8'h03;
        next_cyc();
        bus.fill_start = 1'b0;
        for (k = 0; k < 2000; k++) begin
            #1 chk("mid_fill", {bus.mem_we, bus.mem_addr}, {1'b1, 13'(k)});
            next_cyc();
        end
        rst = 1'b1;
        #1 chk("mid_rst_cnt", {bus.wr_ready, bus.mem_we, bus.mem_addr}, {2'b01, 13'd2000});
        next_cyc();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1 chk("after_abort", {bus.fill_busy, bus.mem_we, bus.fill_done}, 3'b000);
            next_cyc();
        end

        // Partial RAM contents via back-to-back reads
        bus.rd_req = 1'b1; bus.rd_addr = 13'd5;
        next_cyc();
        bus.rd_addr = 13'd3000;
        #1 chk("rd_5", {bus.rd_valid, bus.rd_data}, {1'b1, 8'h03});
        next_cyc();
        bus.rd_req = 1'b0;
        #1 chk("rd_3000", {bus.rd_valid, bus.rd_data}, {1'b1, 8'hE3});
        next_cyc();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
